// File: rtl/spi_burst_ctrl.sv
// Byte sequencer in front of a byte-level SPI driver: TX stream in, one start strobe per byte,
// received byte returned on an RX stream, with inter-byte gap and per-byte watchdog.
module spi_burst_ctrl #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       spi_start,
  output logic [7:0] spi_data_in,
  input  logic [7:0] spi_data_out,
  input  logic       spi_en,
  output logic       busy,
  output logic       burst_active,
  output logic       err_timeout
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [15:0]      tmo_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             spi_en_q, last_q;
  logic             rx_hs, accept, in_wait, done_ev, abort;

  // tx_ready is forced low while rst is held, even though state may already read IDLE
  assign tx_ready  = !rst && (state_q == IDLE) && (!rx_valid || rx_ready);
  assign accept    = tx_valid && tx_ready;
  assign rx_hs     = rx_valid && rx_ready;
  assign in_wait   = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign done_ev   = (state_q == WAIT_DONE) && !spi_en_q && spi_en;
  // The counter value TMO_LAST marks the last allowed wait cycle; done wins a tie
  assign abort     = in_wait && (tmo_cnt_q == TMO_LAST) && !done_ev;

  assign spi_start   = (state_q == LAUNCH);
  assign busy        = (state_q != IDLE);
  assign err_timeout = abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (abort)        state_d = IDLE;
        else if (!spi_en) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_ev)    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        else if (abort) state_d = IDLE;
      end
      GAP:       if (gap_cnt_q == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      spi_en_q     <= 1'b1;
      last_q       <= 1'b0;
      spi_data_in  <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_last      <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      state_q  <= state_d;
      spi_en_q <= spi_en;

      if (state_q == LAUNCH) tmo_cnt_q <= '0;
      else if (in_wait)      tmo_cnt_q <= tmo_cnt_q + 16'd1;

      if (state_q == GAP) gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      else                gap_cnt_q <= '0;

      if (accept) begin
        spi_data_in <= tx_data;
        last_q      <= tx_last;
      end

      if (rx_hs) rx_valid <= 1'b0;
      if (done_ev) begin
        rx_valid <= 1'b1;
        rx_data  <= spi_data_out;
        rx_last  <= last_q;
      end

      // A new burst starting in the same cycle as the previous one ends keeps the flag set
      if (rx_hs && rx_last)  burst_active <= 1'b0;
      if (abort && last_q)   burst_active <= 1'b0;
      if (accept)            burst_active <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: loopback driver models, stream scoreboard, directed corner cases.
module tb_spi_burst_ctrl;
  localparam int GAP = 2;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       tx_valid, tx_ready, tx_last, rx_valid, rx_ready, rx_last;
  logic       spi_start, spi_en, busy, burst_active, err_timeout;
  logic [7:0] tx_data, rx_data, spi_data_in, spi_data_out;

  logic       tx_valid_z, tx_ready_z, tx_last_z, rx_valid_z, rx_ready_z, rx_last_z;
  logic       spi_start_z, spi_en_z, busy_z, burst_active_z, err_timeout_z;
  logic [7:0] tx_data_z, rx_data_z, spi_data_in_z, spi_data_out_z;

  spi_burst_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_last(rx_last), .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_data_out(spi_data_out), .spi_en(spi_en), .busy(busy), .burst_active(burst_active),
    .err_timeout(err_timeout));

  spi_burst_ctrl #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) u_dut_z (
    .clk(clk), .rst(rst), .tx_valid(tx_valid_z), .tx_ready(tx_ready_z), .tx_data(tx_data_z),
    .tx_last(tx_last_z), .rx_valid(rx_valid_z), .rx_ready(rx_ready_z), .rx_data(rx_data_z),
    .rx_last(rx_last_z), .spi_start(spi_start_z), .spi_data_in(spi_data_in_z),
    .spi_data_out(spi_data_out_z), .spi_en(spi_en_z), .busy(busy_z),
    .burst_active(burst_active_z), .err_timeout(err_timeout_z));

  int errors, checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loopback slave: SS low one cycle after start for d_len cycles, returns the inverted byte
  int d_ph, d_len;
  bit d_dead, d_rand;
  logic [7:0] d_byte;
  always @(negedge clk) begin
    if (rst) d_ph = 0;
    else if (spi_start && !d_dead) begin
      d_ph = 1;
      d_byte = spi_data_in;
      if (d_rand) d_len = $urandom_range(1, 8);
    end else if (d_ph != 0) d_ph++;
    spi_en = !(d_ph >= 2 && d_ph < 2 + d_len);
    if (d_ph >= 2 + d_len) d_ph = 0;
    spi_data_out = ~d_byte;
  end

  int z_ph;
  logic [7:0] z_byte;
  always @(negedge clk) begin
    if (rst) z_ph = 0;
    else if (spi_start_z) begin z_ph = 1; z_byte = spi_data_in_z; end
    else if (z_ph != 0) z_ph++;
    spi_en_z = !(z_ph >= 2 && z_ph < 5);
    if (z_ph >= 5) z_ph = 0;
    spi_data_out_z = ~z_byte;
  end

  // Scoreboard: every accepted byte yields its inverse on rx in order, unless the watchdog drops it
  logic [8:0] exp_q[$];
  int cyc, n_start, last_done;
  bit acc_prev, ba_exp, hold_prev, en_prev;
  logic [7:0] acc_byte, rx_prev, ex;
  logic [8:0] e;
  always @(negedge clk) begin
    #2;
    cyc++;
    chk("start_vs_accept", spi_start, acc_prev);
    if (rst) begin
      exp_q.delete();
      acc_prev = 0; ba_exp = 0; hold_prev = 0; last_done = -1; en_prev = 1;
    end else begin
      chk("burst_active", burst_active, ba_exp);
      if (busy) chk("spi_data_in_hold", spi_data_in, acc_byte);
      if (hold_prev) begin
        chk("rx_hold_valid", rx_valid, 1);
        chk("rx_hold_data", rx_data, rx_prev);
      end
      if (rx_valid && !rx_ready) chk("tx_ready_gate", tx_ready, 0);
      if (last_done >= 0 && cyc - last_done >= 1 && cyc - last_done <= GAP)
        chk("gap_hold", tx_ready, 0);
      if (spi_start) n_start++;
      if (spi_en && !en_prev) begin
        if (last_done >= 0) chk("done_spacing", (cyc - last_done) >= GAP + 1, 1);
        last_done = cyc;
      end
      en_prev = spi_en;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          ex = ~e[7:0];
          chk("rx_data", rx_data, ex);
          chk("rx_last", rx_last, e[8]);
          if (e[8]) ba_exp = 0;
        end
      end
      if (err_timeout) begin
        if (exp_q.size() == 0) chk("tmo_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (e[8]) ba_exp = 0;
        end
      end
      hold_prev = rx_valid && !rx_ready;
      rx_prev = rx_data;
      acc_prev = tx_valid && tx_ready;
      if (acc_prev) begin
        exp_q.push_back({tx_last, tx_data});
        acc_byte = tx_data;
        ba_exp = 1;
      end
    end
  end

  task automatic tick(); @(negedge clk); #2; endtask
  task automatic adv();  @(posedge clk); #1; endtask

  task automatic send(input logic [7:0] d, input logic l, output int waited);
    bit ok;
    ok = 0; waited = 0;
    tx_valid = 1; tx_data = d; tx_last = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = tx_ready;
      if (!ok) waited++;
      adv();
    end
    tx_valid = 0; tx_data = 8'h00; tx_last = 0;
    if (!ok) chk("send_timeout", ok, 1);
  endtask

  task automatic wait_rx(output logic [7:0] d, output logic l);
    bit got;
    got = 0; d = '0; l = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (rx_valid && rx_ready) begin got = 1; d = rx_data; l = rx_last; end
      adv();
    end
    if (!got) chk("rx_timeout", got, 1);
  endtask

  typedef struct { logic [7:0] tx; logic last; logic [7:0] rx; logic rl; } vec_t;
  vec_t vt[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic l;
    int w, s0, t0, t1, sent, nrx, done_c, acc2, nacc;
    bit seen, pend, en_p;
    logic [7:0] zb[$];
    logic [7:0] zx;

    errors = 0; checks = 0; cyc = 0; n_start = 0; last_done = -1;
    acc_prev = 0; ba_exp = 0; hold_prev = 0; en_prev = 1; acc_byte = 0; rx_prev = 0;
    d_ph = 0; d_len = 4; d_dead = 0; d_rand = 0; d_byte = 0; z_ph = 0; z_byte = 0;
    rst = 1; tx_valid = 0; tx_data = 0; tx_last = 0; rx_ready = 1;
    tx_valid_z = 0; tx_data_z = 0; tx_last_z = 0; rx_ready_z = 1;
    vt[0] = '{8'hA5, 1'b0, 8'h5A, 1'b0};
    vt[1] = '{8'h3C, 1'b0, 8'hC3, 1'b0};
    vt[2] = '{8'hFF, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h01, 1'b0, 8'hFE, 1'b0};
    vt[4] = '{8'h80, 1'b1, 8'h7F, 1'b1};

    adv(); adv(); adv();
    tick();
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_last", rx_last, 0);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data_in", spi_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_burst_active", burst_active, 0);
    chk("rst_err_timeout", err_timeout, 0);
    adv();
    rst = 0;
    adv();

    s0 = n_start;
    for (int i = 0; i < 5; i++) begin
      send(vt[i].tx, vt[i].last, w);
      if (i > 0) chk("gap_len", w, GAP - 1);
      wait_rx(d, l);
      chk("vec_rx_data", d, vt[i].rx);
      chk("vec_rx_last", l, vt[i].rl);
      if (i == 2) chk("burst_starts", n_start - s0, 3);
    end

    // rx backpressure holds off the next byte; release drains and accepts in one cycle
    rx_ready = 0;
    send(8'h11, 1'b0, w);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin tick(); seen = rx_valid; adv(); end
    chk("bp_rx_seen", seen, 1);
    tx_valid = 1; tx_last = 1;
    for (int i = 0; i < 8; i++) begin
      tx_data = $urandom;
      tick();
      chk("bp_tx_ready", tx_ready, 0);
      chk("bp_no_start", spi_start, 0);
      chk("bp_rx_data", rx_data, 8'hEE);
      adv();
    end
    tx_data = 8'h22; rx_ready = 1;
    tick();
    chk("bp_release_hs", rx_valid, 1);
    chk("bp_release_acc", tx_ready, 1);
    adv();
    tx_valid = 0; tx_last = 0;
    wait_rx(d, l);
    chk("bp_rx2_data", d, 8'hDD);
    chk("bp_rx2_last", l, 1);

    // dead driver: watchdog fires TMO cycles after LAUNCH
    d_dead = 1;
    send(8'h55, 1'b1, w);
    t0 = -1; t1 = -1; seen = 0;
    for (int i = 0; i < 200 && t1 < 0; i++) begin
      tick();
      if (spi_start && t0 < 0) t0 = i;
      if (rx_valid) seen = 1;
      if (err_timeout) t1 = i;
      adv();
    end
    chk("tmo_latency", t1 - t0, TMO);
    chk("tmo_no_rx", seen, 0);
    tick();
    chk("tmo_pulse_width", err_timeout, 0);
    chk("tmo_idle", busy, 0);
    chk("tmo_tx_ready", tx_ready, 1);
    chk("tmo_burst_end", burst_active, 0);
    adv();
    d_dead = 0;

    // done lands on the last allowed wait cycle
    d_len = TMO - 1;
    send(8'h96, 1'b1, w);
    seen = 0; l = 0; d = 0;
    for (int i = 0; i < 200 && !l; i++) begin
      tick();
      if (err_timeout) seen = 1;
      if (rx_valid) begin l = 1; d = rx_data; end
      adv();
    end
    chk("tie_no_err", seen, 0);
    chk("tie_rx_data", d, 8'h69);
    d_len = 4;

    // reset while waiting for done
    d_len = 20;
    send(8'h42, 1'b0, w);
    for (int i = 0; i < 4; i++) adv();
    tick();
    chk("mid_busy", busy, 1);
    adv();
    rst = 1;
    tick(); adv();
    rst = 0;
    tick();
    chk("mid_spi_start", spi_start, 0);
    chk("mid_rx_valid", rx_valid, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_burst_clr", burst_active, 0);
    adv();
    d_len = 4;
    send(8'h0F, 1'b1, w);
    wait_rx(d, l);
    chk("post_rst_data", d, 8'hF0);
    chk("post_rst_last", l, 1);

    // randomized traffic against the scoreboard
    d_rand = 1; sent = 0; pend = 0;
    for (int c = 0; c < 20000 && sent < 150; c++) begin
      if (!pend && $urandom_range(0, 2) == 0) pend = 1;
      tx_valid = pend; tx_data = $urandom; tx_last = ($urandom_range(0, 3) == 0);
      rx_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (tx_valid && tx_ready) begin sent++; pend = 0; end
      adv();
    end
    tx_valid = 0; tx_last = 0; rx_ready = 1;
    for (int c = 0; c < 200; c++) begin
      adv();
      if (exp_q.size() == 0 && !rx_valid) break;
    end
    chk("rand_sent", sent, 150);
    chk("rand_drained", exp_q.size(), 0);
    d_rand = 0;

    // zero-gap build: next byte accepted right after done; stalled tx_data ignored
    tx_valid_z = 1; tx_last_z = 0; rx_ready_z = 1;
    nacc = 0; nrx = 0; done_c = -1; acc2 = -1; en_p = 1;
    for (int i = 0; i < 100 && nrx < 2; i++) begin
      tx_data_z = $urandom;
      tick();
      chk("gap0_no_err", err_timeout_z, 0);
      if (spi_en_z && !en_p && done_c < 0) done_c = i;
      en_p = spi_en_z;
      if (rx_valid_z) begin
        nrx++;
        if (zb.size() == 0) chk("gap0_rx_unexpected", 1, 0);
        else begin zx = ~zb.pop_front(); chk("gap0_rx_data", rx_data_z, zx); end
        chk("gap0_rx_last", rx_last_z, nrx == 2);
      end
      if (tx_valid_z && tx_ready_z) begin
        zb.push_back(tx_data_z);
        nacc++;
        if (nacc == 2) acc2 = i;
      end
      adv();
      if (nacc == 1) tx_last_z = 1;
      if (nacc == 2) begin tx_valid_z = 0; tx_last_z = 0; end
    end
    chk("gap0_accept_after_done", acc2 - done_c, 1);
    chk("gap0_rx_count", nrx, 2);

    adv(); adv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
